// File: rtl/booth_acc_reg.sv
// ---------------------------------------------------------------------------
// booth_acc_reg
//
// Accumulator (A) register for the sequential Booth multiplier datapath.
// Holds the partial product, captures the adder sum or a bus value, and runs
// a self-timed multi-step right shift so the controller issues one command
// per shift sequence instead of one per cycle.
//
// Parameters
//   WIDTH     register / data width in bits (>= 4)
//   STEP_BITS bits shifted per step: 1 = radix-2, 2 = radix-4
//   CNT_W     width of the step-count input (max 2^CNT_W - 1 steps)
//
// Ports
//   clk       rising-edge clock
//   rst_b     asynchronous active-low reset
//   clr       synchronous clear of q / lsb_out, aborts a running shift
//   ld_sum    load q from sum        (IDLE/DONE only)
//   sum       adder result
//   ld_bus    load q from ibus       (IDLE/DONE only)
//   ibus      input bus value
//   sh_start  start a shift sequence (IDLE/DONE only)
//   sh_steps  number of steps in the sequence (0 = go straight to DONE)
//   sh_arith  1 = arithmetic shift, 0 = logical shift filled with sh_in
//   sh_in     fill bit for logical shift
//   out_en    drive obus with q, otherwise obus is high-Z
//   q         register contents
//   lsb_out   bits shifted out by the most recent step
//   obus      tri-state copy of q
//   busy      high while shifting
//   done      one-cycle pulse after a sequence completes
// ---------------------------------------------------------------------------
module booth_acc_reg #(
    parameter int WIDTH     = 8,
    parameter int STEP_BITS = 1,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 clr,
    input  logic                 ld_sum,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 ld_bus,
    input  logic [WIDTH-1:0]     ibus,
    input  logic                 sh_start,
    input  logic [CNT_W-1:0]     sh_steps,
    input  logic                 sh_arith,
    input  logic                 sh_in,
    input  logic                 out_en,
    output logic [WIDTH-1:0]     q,
    output logic [STEP_BITS-1:0] lsb_out,
    output logic [WIDTH-1:0]     obus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [STEP_BITS-1:0] lsb_q, lsb_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 arith_q, arith_d;
    logic                 fill_q, fill_d;

    // Vacated MSBs: the current sign bit for arithmetic shifts (taken from
    // the live register so repeated steps keep replicating the sign), or the
    // fill bit latched at sh_start for logical shifts.
    logic [STEP_BITS-1:0] fill_bits;
    logic [WIDTH-1:0]     shifted;

    genvar gi;
    generate
        for (gi = 0; gi < STEP_BITS; gi++) begin : g_fill
            assign fill_bits[gi] = arith_q ? acc_q[WIDTH-1] : fill_q;
        end
    endgenerate

    assign shifted = {fill_bits, acc_q[WIDTH-1:STEP_BITS]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lsb_d   = lsb_q;
        cnt_d   = cnt_q;
        arith_d = arith_q;
        fill_d  = fill_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE lasts exactly one cycle unless a new command arrives.
                state_d = ST_IDLE;
                if (clr) begin
                    acc_d = '0;
                    lsb_d = '0;
                end else if (ld_sum) begin
                    acc_d = sum;
                end else if (ld_bus) begin
                    acc_d = ibus;
                end else if (sh_start) begin
                    arith_d = sh_arith;
                    fill_d  = sh_in;
                    cnt_d   = sh_steps;
                    state_d = (sh_steps == '0) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // Loads and new starts are dropped here; only clr is honoured.
                if (clr) begin
                    acc_d   = '0;
                    lsb_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = shifted;
                    lsb_d = acc_q[STEP_BITS-1:0];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            lsb_q   <= '0;
            cnt_q   <= '0;
            arith_q <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lsb_q   <= lsb_d;
            cnt_q   <= cnt_d;
            arith_q <= arith_d;
            fill_q  <= fill_d;
        end
    end

    assign q       = acc_q;
    assign lsb_out = lsb_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);
    assign obus    = out_en ? acc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_booth_acc_reg.sv
// ---------------------------------------------------------------------------
// tb_booth_acc_reg
//
// Drives a radix-2 and a radix-4 instance with identical commands. Every
// cycle both are compared against a behavioural model; a table of vectors
// with hand-computed results and a few hand-written multi-cycle sequences
// cover the corner cases, followed by a random phase.
// ---------------------------------------------------------------------------
module tb_booth_acc_reg;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       clr, ld_sum, ld_bus, sh_start, sh_arith, sh_in, out_en;
    logic [7:0] sum, ibus;
    logic [3:0] sh_steps;

    logic [7:0] q2, obus2, q4, obus4;
    logic [0:0] lsb2;
    logic [1:0] lsb4;
    logic       busy2, done2, busy4, done4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_acc_reg #(.WIDTH(8), .STEP_BITS(1), .CNT_W(4)) u_r2 (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld_sum(ld_sum), .sum(sum),
        .ld_bus(ld_bus), .ibus(ibus), .sh_start(sh_start), .sh_steps(sh_steps),
        .sh_arith(sh_arith), .sh_in(sh_in), .out_en(out_en),
        .q(q2), .lsb_out(lsb2), .obus(obus2), .busy(busy2), .done(done2)
    );

    booth_acc_reg #(.WIDTH(8), .STEP_BITS(2), .CNT_W(4)) u_r4 (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld_sum(ld_sum), .sum(sum),
        .ld_bus(ld_bus), .ibus(ibus), .sh_start(sh_start), .sh_steps(sh_steps),
        .sh_arith(sh_arith), .sh_in(sh_in), .out_en(out_en),
        .q(q4), .lsb_out(lsb4), .obus(obus4), .busy(busy4), .done(done4)
    );

    // ---------------- behavioural model (index 0 = radix-2, 1 = radix-4)
    logic [7:0] m_q[2];
    logic [7:0] m_lsb[2];
    logic       m_busy[2], m_done[2], m_arith[2], m_fill[2];
    int         m_rem[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 8'h00; m_lsb[i] = 8'h00;
            m_busy[i] = 1'b0; m_done[i] = 1'b0;
            m_rem[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic signed [7:0] sq;
        logic [7:0]        mask;
        int                s;
        if (!rst_b) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            s = i + 1;
            if (m_busy[i]) begin
                if (clr) begin
                    m_q[i] = 8'h00; m_lsb[i] = 8'h00; m_busy[i] = 1'b0;
                end else begin
                    m_lsb[i] = m_q[i] % 8'((1 << s));
                    if (m_arith[i]) begin
                        sq = m_q[i];
                        m_q[i] = sq >>> s;
                    end else begin
                        mask = 8'hFF;
                        mask = mask << (8 - s);
                        m_q[i] = (m_q[i] >> s) | (m_fill[i] ? mask : 8'h00);
                    end
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end else begin
                m_done[i] = 1'b0;
                if (clr) begin
                    m_q[i] = 8'h00; m_lsb[i] = 8'h00;
                end else if (ld_sum) begin
                    m_q[i] = sum;
                end else if (ld_bus) begin
                    m_q[i] = ibus;
                end else if (sh_start) begin
                    m_arith[i] = sh_arith;
                    m_fill[i]  = sh_in;
                    if (sh_steps == 4'd0) m_done[i] = 1'b1;
                    else begin
                        m_busy[i] = 1'b1;
                        m_rem[i]  = int'(sh_steps);
                    end
                end
            end
        end
    endtask

    // ---------------- comparison helpers
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // A released bus reads as Z on four-state simulators and 0 on two-state ones.
    task automatic chk_bus(input string name, input logic [7:0] act, input logic [7:0] qexp);
        logic ok;
        checks++;
        if (out_en) ok = (act === qexp);
        else        ok = (act === 8'hzz) || (act === 8'h00);
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h out_en=%0b", name, act,
                     out_en ? qexp : 8'hzz, out_en);
        end
    endtask

    task automatic compare_all();
        chk("r2_q",    q2,              m_q[0]);
        chk("r2_lsb",  {7'b0, lsb2},    m_lsb[0]);
        chk("r2_busy", {7'b0, busy2},   {7'b0, m_busy[0]});
        chk("r2_done", {7'b0, done2},   {7'b0, m_done[0]});
        chk_bus("r2_obus", obus2, m_q[0]);
        chk("r4_q",    q4,              m_q[1]);
        chk("r4_lsb",  {6'b0, lsb4},    m_lsb[1]);
        chk("r4_busy", {7'b0, busy4},   {7'b0, m_busy[1]});
        chk("r4_done", {7'b0, done4},   {7'b0, m_done[1]});
        chk_bus("r4_obus", obus4, m_q[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic c, input logic ls, input logic [7:0] s,
                          input logic lb, input logic [7:0] b, input logic st,
                          input logic [3:0] n, input logic ar, input logic f);
        clr = c; ld_sum = ls; sum = s; ld_bus = lb; ibus = b;
        sh_start = st; sh_steps = n; sh_arith = ar; sh_in = f;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // ---------------- vector table (expectations for the radix-2 instance)
    typedef struct {
        logic       clr;
        logic       ld_sum;
        logic [7:0] sum;
        logic       ld_bus;
        logic [7:0] ibus;
        logic       start;
        logic [3:0] steps;
        logic       arith;
        logic       fill;
        logic [7:0] e_q;
        logic       e_lsb;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //          clr ls  sum    lb  ibus   st  n     ar  f    q      lsb busy done
        vecs[0]  = '{0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0, 8'h96, 0, 0, 0};
        vecs[1]  = '{0, 0, 8'h00, 0, 8'h00, 1, 4'd3, 1, 0, 8'h96, 0, 1, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'hCB, 0, 1, 0};
        vecs[3]  = '{0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'hE5, 1, 1, 0};
        vecs[4]  = '{0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'hF2, 1, 0, 1};
        vecs[5]  = '{0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'hF2, 1, 0, 0};
        vecs[6]  = '{0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0, 8'h96, 1, 0, 0};
        vecs[7]  = '{0, 0, 8'h00, 0, 8'h00, 1, 4'd1, 0, 0, 8'h96, 1, 1, 0};
        vecs[8]  = '{0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'h4B, 0, 0, 1};
        vecs[9]  = '{0, 0, 8'h00, 0, 8'h00, 1, 4'd0, 0, 0, 8'h4B, 0, 0, 1};
        vecs[10] = '{0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'h4B, 0, 0, 0};
        vecs[11] = '{0, 1, 8'h5A, 0, 8'h00, 0, 4'd0, 0, 0, 8'h5A, 0, 0, 0};
        vecs[12] = '{1, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0, 8'h00, 0, 0, 0};
        vecs[13] = '{1, 1, 8'h33, 0, 8'h00, 1, 4'd2, 1, 0, 8'h00, 0, 0, 0};
        vecs[14] = '{0, 1, 8'h33, 0, 8'h00, 0, 4'd0, 0, 0, 8'h33, 0, 0, 0};
    end

    // ---------------- stimulus
    initial begin
        rst_b  = 1'b0;
        out_en = 1'b1;
        idle_in();
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        @(negedge clk);
        rst_b = 1'b1;

        // table-driven vectors
        for (int v = 0; v < 15; v++) begin
            set_in(vecs[v].clr, vecs[v].ld_sum, vecs[v].sum, vecs[v].ld_bus,
                   vecs[v].ibus, vecs[v].start, vecs[v].steps, vecs[v].arith,
                   vecs[v].fill);
            cycle();
            chk($sformatf("vec%0d_q", v),    q2,              vecs[v].e_q);
            chk($sformatf("vec%0d_lsb", v),  {7'b0, lsb2},    {7'b0, vecs[v].e_lsb});
            chk($sformatf("vec%0d_busy", v), {7'b0, busy2},   {7'b0, vecs[v].e_busy});
            chk($sformatf("vec%0d_done", v), {7'b0, done2},   {7'b0, vecs[v].e_done});
        end

        // radix-4: two single arithmetic steps from 0x96
        set_in(0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd1, 1, 0); cycle();
        idle_in(); cycle();
        chk("r4_step1_q", q4, 8'hE5);
        chk("r4_step1_lsb", {6'b0, lsb4}, 8'h02);
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd1, 1, 0); cycle();
        idle_in(); cycle();
        chk("r4_step2_q", q4, 8'hF9);
        chk("r4_step2_lsb", {6'b0, lsb4}, 8'h01);
        cycle();

        // ld_sum while shifting is ignored
        set_in(0, 0, 8'h00, 1, 8'h80, 0, 4'd0, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd3, 1, 0); cycle();
        set_in(0, 1, 8'h33, 0, 8'h00, 0, 4'd0, 0, 0); cycle(); cycle(); cycle();
        chk("ldsum_ignored_q", q2, 8'hF0);
        chk("ldsum_ignored_done", {7'b0, done2}, 8'h01);
        idle_in(); cycle();

        // clr aborts a running shift with no done pulse
        set_in(0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd4, 1, 0); cycle();
        idle_in(); cycle();
        set_in(1, 0, 8'h00, 0, 8'h00, 0, 4'd0, 0, 0); cycle();
        chk("abort_q", q2, 8'h00);
        chk("abort_busy", {7'b0, busy2}, 8'h00);
        idle_in(); cycle();
        chk("abort_no_done", {7'b0, done2}, 8'h00);

        // mode bits are latched at start; toggling them mid-sequence has no effect
        out_en = 1'b0;
        set_in(0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd2, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 0, 4'd0, 1, 1); cycle(); cycle();
        chk("latched_mode_q", q2, 8'h25);
        out_en = 1'b1;
        idle_in(); cycle();

        // back-to-back: start accepted in the DONE cycle
        set_in(0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd2, 1, 0); cycle();
        idle_in(); cycle(); cycle();
        chk("b2b_first_done", {7'b0, done2}, 8'h01);
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd1, 1, 0); cycle();
        chk("b2b_second_busy", {7'b0, busy2}, 8'h01);
        idle_in(); cycle();
        chk("b2b_second_q", q2, 8'hF2);
        cycle();

        // asynchronous reset in the middle of a sequence
        set_in(0, 0, 8'h00, 1, 8'h96, 0, 4'd0, 0, 0); cycle();
        set_in(0, 0, 8'h00, 0, 8'h00, 1, 4'd5, 1, 0); cycle();
        idle_in(); cycle();
        #3;
        rst_b = 1'b0;
        #1;
        model_reset();
        chk("async_rst_q", q2, 8'h00);
        chk("async_rst_busy", {7'b0, busy2}, 8'h00);
        compare_all();
        cycle(); cycle();
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // random phase
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 31) == 0, $urandom_range(0, 9) == 0,
                   8'($urandom), $urandom_range(0, 9) == 0, 8'($urandom),
                   $urandom_range(0, 3) == 0, 4'($urandom_range(0, 6)),
                   1'($urandom), 1'($urandom));
            out_en = 1'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_acc_reg.md
Name: booth_acc_reg

Overview:
Parametrised accumulator (A) register for the sequential Booth multiplier datapath.
- Holds the partial product and captures the adder sum or a bus value.
- Runs a multi-step right shift (radix-2 or radix-4 step size) under a start/busy/done handshake, so the controller issues one command per shift sequence instead of one per cycle.
- Exposes the bits shifted out last and drives the shared output bus through a tri-state enable.

Parameters:
WIDTH, 8, register and data width in bits (>= 4)
STEP_BITS, 1, bits shifted per step: 1 = radix-2 Booth, 2 = radix-4 Booth; other values illegal
CNT_W, 4, width of the step-count input; max sequence length 2^CNT_W - 1 steps

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear of q and lsb_out; aborts a running shift
ld_sum  input  1  load q from sum
sum  input  WIDTH  adder result
ld_bus  input  1  load q from ibus
ibus  input  WIDTH  input bus value
sh_start  input  1  start a shift sequence
sh_steps  input  CNT_W  number of shift steps for this sequence
sh_arith  input  1  1 = arithmetic (sign-replicate), 0 = logical (fill with sh_in)
sh_in  input  1  fill bit for logical shift
out_en  input  1  drive obus with q
q  output  WIDTH  register contents
lsb_out  output  STEP_BITS  bits shifted out by the most recent step
obus  output  WIDTH  q when out_en = 1, else high-Z
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse after a sequence completes

Behaviour:
- Reset (rst_b = 0, asynchronous): state = IDLE, q = 0, lsb_out = 0, busy = 0, done = 0. The counter and latched mode bits are don't-care. Reset mid-sequence abandons it with no done pulse.
- States:
  - IDLE and DONE both accept commands.
  - SHIFT is the only state with busy = 1.
  - done = 1 exactly when state = DONE. DONE always returns to IDLE at the next edge unless a new command is accepted.
- Command priority at each edge in IDLE/DONE: clr > ld_sum > ld_bus > sh_start. Exactly one action is taken.
  - clr: q <= 0, lsb_out <= 0.
  - ld_sum / ld_bus: q <= sum / ibus; lsb_out unchanged.
- sh_start accepted at edge k:
  - Latch sh_arith and sh_in for the whole sequence; later changes on those inputs have no effect.
  - Load the counter with sh_steps and go to SHIFT.
  - If sh_steps = 0: go straight to DONE; q is unchanged.
- SHIFT, one step per edge at edges k+1 .. k+N:
  - q <= q shifted right by STEP_BITS.
  - Vacated MSBs = q[WIDTH-1] if arithmetic, else the latched sh_in (replicated STEP_BITS times).
  - lsb_out <= q[STEP_BITS-1:0] (pre-shift value).
  - Counter decrements. On the edge that performs the final step, go to DONE.
- Done timing: done is high for the cycle after edge k+N; busy is high from after edge k until edge k+N.
- While in SHIFT:
  - ld_sum, ld_bus and sh_start are ignored and the commands are lost, not queued.
  - clr aborts: q <= 0, lsb_out <= 0, state <= IDLE, no done pulse.
- The sign bit is preserved across every arithmetic step, including repeated steps; the MSB never takes a stale value.
- obus is combinational: q when out_en = 1, else all-Z, independent of state; q is visible while shifting.
- No arithmetic is performed here; q width is fixed at WIDTH with no overflow handling.

Test Plan:
1. Reset/clear: assert rst_b = 0 mid-SHIFT -> q = 0x00, busy = 0, done = 0 immediately (asynchronous), no done pulse afterwards. ld_sum 0x5A then clr -> q = 0x00, lsb_out = 0.
2. Radix-2 arithmetic, WIDTH = 8: ld_bus 0x96, sh_start with sh_steps = 3, sh_arith = 1 -> q steps 0xCB, 0xE5, 0xF2; lsb_out steps 0, 1, 1; busy for 3 cycles; done pulses once in the cycle after the 3rd shift.
3. Logical and zero-length: ld_bus 0x96, sh_steps = 1, sh_arith = 0, sh_in = 0 -> q = 0x4B, lsb_out = 0. Then sh_steps = 0 -> done pulses at the next cycle, q still 0x4B, busy never asserted.
4. Radix-4 (STEP_BITS = 2): ld_bus 0x96, one arithmetic step -> q = 0xE5, lsb_out = 2'b10. A second step -> q = 0xF9, lsb_out = 2'b01.
5. Priority and collisions:
   - clr + ld_sum + sh_start in the same IDLE cycle -> q = 0, no shift.
   - ld_sum 0x33 asserted during SHIFT -> ignored, sequence completes normally.
   - clr during SHIFT -> q = 0, IDLE, no done pulse.
   - sh_arith toggled mid-sequence -> no effect.
6. Bus and back-to-back: out_en = 0 -> obus all Z; out_en = 1 -> obus = q, tracking each shift. A new sh_start issued in the DONE cycle is accepted and the next sequence runs without an idle gap.
